tt_um_cla_seq: RTL and testbench
================================

TT_UM_CLA_SEQ -- requirements
Module: tt_um_cla_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port ena, input, 1 bit: when 0, all state and registers hold.
REQ-004 SHALL have port ui_in, input, 8 bits: operand data byte.
REQ-005 SHALL have port uio_in, input, 8 bits:
- [0] in_valid
- [1] out_ack
- [2] sub
- [3] cin
- [4] clr
- [7:5] unused
REQ-006 SHALL have port uo_out, output, 8 bits: result byte.
REQ-007 SHALL have port uio_out, output, 8 bits:
- [7] busy
- [6] done
- [5] cout
- [4] ovf
- [3:0] = 0
REQ-008 SHALL have port uio_oe, output, 8 bits: constant 8'hF0.

Function
REQ-009 SHALL implement a 16-bit add/subtract sequencer that drives one 4-bit CLA slice across four nibbles, one nibble per cycle.
REQ-010 SHALL implement states A_LO, A_HI, B_LO, B_HI, CALC, RES_LO and RES_HI.
REQ-011 In A_LO, A_HI, B_LO and B_HI, a cycle with in_valid=1 SHALL store ui_in into A[7:0], A[15:8], B[7:0] or B[15:8] respectively, then advance to the next state.
REQ-012 On the B_HI capture edge, the block SHALL latch sub and cin and clear the nibble index to 0.
REQ-013 In CALC, each cycle SHALL apply the slice inputs and store the results as follows:
- slice A input = A nibble[idx]
- slice B input = B nibble[idx] XOR {4{sub}}
- slice carry-in = (cin XOR sub) for idx 0, else carry register
- store the sum nibble into R[idx]
- load the carry register from the slice cout
- increment idx
REQ-014 After the idx=3 cycle, the block SHALL set cout = final slice carry and ovf = (A[15] == Beff[15]) && (R[15] != A[15]), then enter RES_LO; done SHALL assert exactly 4 cycles after the B_HI capture edge.
REQ-015 In RES_LO, uo_out SHALL be R[7:0]; out_ack=1 SHALL advance the state to RES_HI.
REQ-016 In RES_HI, uo_out SHALL be R[15:8]; out_ack=1 SHALL return the state to A_LO.
REQ-017 In all other states, uo_out SHALL be 0.
REQ-018 done SHALL be 1 only in RES_LO and RES_HI; busy SHALL be 1 only in CALC.
REQ-019 cout and ovf SHALL hold their last computed values until the next CALC completes.
REQ-020 The block SHALL ignore in_valid in CALC, RES_LO and RES_HI.
REQ-021 The block SHALL ignore out_ack outside RES_LO and RES_HI.
REQ-022 If in_valid and out_ack are both 1 in RES_LO or RES_HI, out_ack SHALL be honoured and in_valid ignored.
REQ-023 clr=1 (with ena=1) SHALL synchronously force state A_LO, clear A, B, R, idx, the carry register, cout and ovf, and take priority over every other input in every state, including mid-CALC.
REQ-024 Arithmetic SHALL be modulo 2^16.
REQ-025 For subtract, cout=1 SHALL mean no borrow.

Reset
REQ-026 rst_n=0 SHALL asynchronously force the following, regardless of ena:
- state A_LO
- A, B, R, idx, carry register = 0
- uo_out = 0
- uio_out = 0
- uio_oe = 8'hF0
REQ-027 A reset asserted mid-CALC SHALL discard the operation; no done SHALL follow.
REQ-028 After rst_n deasserts, the first capture SHALL occur on the first in_valid=1 edge.

Structure
REQ-029 Package cla_pkg SHALL hold the state enum, WIDTH=16, NIB=4 and NIBBLES=4.
REQ-030 There SHALL be one sub-module, cla4: a combinational 4-bit carry-lookahead slice with a, b, cin, sum and cout, instantiated exactly once.
REQ-031 All registers SHALL live in tt_um_cla_seq.

Verification
REQ-032 The bench SHALL load A=0x1234, B=0x0FCD with sub=0, cin=0 and check R=0x2201, cout=0, ovf=0, with done 4 cycles after B_HI.
REQ-033 The bench SHALL load A=0xFFFF, B=0x0001 with sub=0, cin=0 and check R=0x0000, cout=1, ovf=0.
REQ-034 The bench SHALL load A=0x7FFF, B=0x0001 with sub=0, cin=0 and check R=0x8000, cout=0, ovf=1.
REQ-035 The bench SHALL load A=0x0005, B=0x0007 with sub=1 and check R=0xFFFE, cout=0 (borrow), ovf=0.
REQ-036 The bench SHALL pulse rst_n low during CALC idx=2 and check that outputs go to 0 immediately, state is A_LO, and done stays 0; it SHALL then complete a new add correctly.
REQ-037 The bench SHALL check these gating cases:
- in_valid during CALC: no register change
- out_ack in A_LO: no effect
- clr in B_LO: next cycle A_LO with A=0
- ena=0 for 3 cycles mid-CALC: done delayed by exactly 3 cycles

Source files
------------

// File: rtl/cla_pkg.sv
// Shared widths and sequencer state encoding for the nibble-serial CLA add/subtract block.
package cla_pkg;
  localparam int WIDTH   = 16;
  localparam int NIB     = 4;
  localparam int NIBBLES = WIDTH / NIB;

  typedef enum logic [2:0] {
    A_LO, A_HI, B_LO, B_HI, CALC, RES_LO, RES_HI
  } state_t;
endpackage

// File: rtl/cla4.sv
// Combinational 4-bit carry-lookahead adder slice, reused once per nibble by the sequencer.
module cla4
  import cla_pkg::*;
(
  input  logic [NIB-1:0] a,
  input  logic [NIB-1:0] b,
  input  logic           cin,
  output logic [NIB-1:0] sum,
  output logic           cout
);
  logic [NIB-1:0] w_g;
  logic [NIB-1:0] w_p;
  logic [NIB:0]   w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

  assign sum  = w_p ^ w_c[NIB-1:0];
  assign cout = w_c[NIB];
endmodule

// File: rtl/tt_um_cla_seq.sv
// 16-bit add/subtract sequencer: byte-wise operand load, one CLA nibble per cycle, byte-wise readout.
//
// state  | meaning
// A_LO   | waiting for A[7:0]
// A_HI   | waiting for A[15:8]
// B_LO   | waiting for B[7:0]
// B_HI   | waiting for B[15:8]; capture latches sub/cin
// CALC   | one nibble per cycle through cla4, idx 0..3
// RES_LO | presenting R[7:0], waiting for out_ack
// RES_HI | presenting R[15:8], waiting for out_ack
module tt_um_cla_seq
  import cla_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  logic w_in_valid, w_out_ack, w_sub, w_cin, w_clr, w_unused;
  assign w_in_valid = uio_in[0];
  assign w_out_ack  = uio_in[1];
  assign w_sub      = uio_in[2];
  assign w_cin      = uio_in[3];
  assign w_clr      = uio_in[4];
  assign w_unused   = &{1'b0, uio_in[7:5]};

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_r;
  logic [1:0]       r_idx;
  logic             r_carry, r_sub, r_cin, r_cout, r_ovf;

  logic [NIB-1:0] w_slice_a, w_slice_b, w_sum;
  logic           w_slice_cin, w_slice_cout, w_last, w_beff_msb;

  assign w_slice_a   = r_a[NIB*r_idx +: NIB];
  assign w_slice_b   = r_b[NIB*r_idx +: NIB] ^ {NIB{r_sub}};
  assign w_slice_cin = (r_idx == 2'd0) ? (r_cin ^ r_sub) : r_carry;
  assign w_last      = (r_idx == 2'(NIBBLES - 1));
  assign w_beff_msb  = r_b[WIDTH-1] ^ r_sub;

  cla4 u_cla4 (
    .a    (w_slice_a),
    .b    (w_slice_b),
    .cin  (w_slice_cin),
    .sum  (w_sum),
    .cout (w_slice_cout)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (w_clr) begin
      w_state_nxt = A_LO;
    end else begin
      case (r_state)
        A_LO:    if (w_in_valid) w_state_nxt = A_HI;
        A_HI:    if (w_in_valid) w_state_nxt = B_LO;
        B_LO:    if (w_in_valid) w_state_nxt = B_HI;
        B_HI:    if (w_in_valid) w_state_nxt = CALC;
        CALC:    if (w_last)     w_state_nxt = RES_LO;
        RES_LO:  if (w_out_ack)  w_state_nxt = RES_HI;
        RES_HI:  if (w_out_ack)  w_state_nxt = A_LO;
        default:                 w_state_nxt = A_LO;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_state <= A_LO;
    else if (ena) r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0; r_b <= '0; r_r <= '0; r_idx <= '0;
      r_carry <= 1'b0; r_sub <= 1'b0; r_cin <= 1'b0; r_cout <= 1'b0; r_ovf <= 1'b0;
    end else if (ena) begin
      if (w_clr) begin
        r_a <= '0; r_b <= '0; r_r <= '0; r_idx <= '0;
        r_carry <= 1'b0; r_sub <= 1'b0; r_cin <= 1'b0; r_cout <= 1'b0; r_ovf <= 1'b0;
      end else begin
        case (r_state)
          A_LO: if (w_in_valid) r_a[7:0]  <= ui_in;
          A_HI: if (w_in_valid) r_a[15:8] <= ui_in;
          B_LO: if (w_in_valid) r_b[7:0]  <= ui_in;
          B_HI: if (w_in_valid) begin
            r_b[15:8] <= ui_in;
            r_sub     <= w_sub;
            r_cin     <= w_cin;
            r_idx     <= '0;
          end
          CALC: begin
            r_r[NIB*r_idx +: NIB] <= w_sum;
            r_carry <= w_slice_cout;
            r_idx   <= r_idx + 2'd1;
            if (w_last) begin
              // w_sum[NIB-1] is R[15] on the final nibble.
              r_cout <= w_slice_cout;
              r_ovf  <= (r_a[WIDTH-1] == w_beff_msb) && (w_sum[NIB-1] != r_a[WIDTH-1]);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    uo_out = 8'h00;
    case (r_state)
      RES_LO:  uo_out = r_r[7:0];
      RES_HI:  uo_out = r_r[15:8];
      default: uo_out = 8'h00;
    endcase
  end

  assign uio_out = {(r_state == CALC), (r_state == RES_LO) || (r_state == RES_HI),
                    r_cout, r_ovf, 4'b0000};
  assign uio_oe  = 8'hF0;
endmodule

// File: tb/tb_tt_um_cla_seq.sv
// Scoreboard bench for tt_um_cla_seq: driver pushes expected results, negedge monitor pops and compares.
module tb_tt_um_cla_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic       in_valid = 1'b0, out_ack = 1'b0, sub = 1'b0, cin = 1'b0, clr = 1'b0;
  logic [7:0] uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;

  assign uio_in = {3'b000, clr, cin, sub, out_ack, in_valid};

  tt_um_cla_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] r;
    logic        c;
    logic        o;
    logic [31:0] cyc;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: first done cycle checks low byte/flags/latency, cycle after the first ack checks high byte.
  int   phase = 0;
  exp_t cur;
  always @(negedge clk) begin
    if (!rst_n) begin
      phase = 0;
    end else begin
      if (!uio_out[6]) begin
        phase = 0;
      end else if (phase == 0) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending result at t=%0t", $time);
        end else begin
          cur = sbq.pop_front();
          chk("res_lo", 32'(uo_out), 32'(cur.r[7:0]));
          chk("cout", 32'(uio_out[5]), 32'(cur.c));
          chk("ovf", 32'(uio_out[4]), 32'(cur.o));
          chk("done_cycle", 32'(cyc), cur.cyc);
        end
        phase = 1;
      end else if (phase == 2) begin
        chk("res_hi", 32'(uo_out), 32'(cur.r[15:8]));
        phase = 3;
      end
      if (uio_out[6] && out_ack && ena && phase == 1) phase = 2;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] d);
    ui_in = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load4(input logic [15:0] a, input logic [15:0] b, input logic s, input logic c);
    sub = s;
    cin = c;
    put(a[7:0]);
    put(a[15:8]);
    put(b[7:0]);
    put(b[15:8]);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s, input logic c,
                        input logic [15:0] er, input logic ec, input logic eo,
                        input int stall, input bit noise);
    int n;
    load4(a, b, s, c);
    sbq.push_back({er, ec, eo, 32'(cyc + 4 + stall)});
    if (noise) begin
      in_valid = 1'b1; ui_in = 8'hAA; sub = ~s; cin = ~c;
      tick(); tick();
      in_valid = 1'b0;
    end
    if (stall > 0) begin
      tick();
      ena = 1'b0;
      repeat (stall) tick();
      ena = 1'b1;
    end
    n = 0;
    while (!uio_out[6] && n < 20) begin
      tick();
      n++;
    end
    if (!uio_out[6]) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got done=0 expected done=1 within 20 cycles");
    end
    out_ack = 1'b1; tick(); out_ack = 1'b0; tick();
    out_ack = 1'b1; tick(); out_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_uo_out", 32'(uo_out), 32'h00);
    chk("rst_uio_out", 32'(uio_out), 32'h00);
    chk("rst_uio_oe", 32'(uio_oe), 32'hF0);
    rst_n = 1'b1;
    tick();

    run_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0, 0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0, 1'b0);
    run_op(16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 0, 1'b0);
    run_op(16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0, 0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 0, 1'b1);

    // out_ack while idle: nothing moves, last cout/ovf stay visible
    out_ack = 1'b1; tick(); out_ack = 1'b0;
    chk("idle_ack_uo_out", 32'(uo_out), 32'h00);
    chk("idle_ack_uio_out", 32'(uio_out), 32'h30);

    // clr while waiting for B low byte
    put(8'h34); put(8'h12);
    ui_in = 8'h56; in_valid = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_uio_out", 32'(uio_out), 32'h00);
    run_op(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, 0, 1'b0);

    run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 3, 1'b0);

    // reset pulse with CALC at idx=2
    load4(16'h4444, 16'h1111, 1'b0, 1'b0);
    tick(); tick();
    chk("busy_before_rst", 32'(uio_out[7]), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_uo_out", 32'(uo_out), 32'h00);
    chk("midrst_uio_out", 32'(uio_out), 32'h00);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("no_done_after_rst", 32'(uio_out[6]), 32'h0);
    end
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h0101, 1'b0, 1'b0, 0, 1'b0);

    tick();
    chk("scoreboard_empty", 32'(sbq.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
